// File: rtl/dma_pkg.sv
// Shared types and slot-map constants for the chip-bus DMA slot scheduler.
//   owner_t    : owner code published on slot_owner
//   *_FIRST/*_LAST : odd-hpos ranges of the fixed-slot channels
package dma_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    REFRESH = 4'd1,
    DISK    = 4'd2,
    AUD     = 4'd3,
    SPR     = 4'd4,
    BPL     = 4'd5,
    COP     = 4'd6,
    BLT     = 4'd7,
    CPU     = 4'd8
  } owner_t;

  // Fixed slots occupy odd hpos values only; even slots are always free.
  localparam logic [7:0] REF_FIRST = 8'd1;
  localparam logic [7:0] REF_LAST  = 8'd7;
  localparam logic [7:0] DSK_FIRST = 8'd9;
  localparam logic [7:0] DSK_LAST  = 8'd13;
  localparam logic [7:0] AUD_FIRST = 8'd15;
  localparam logic [7:0] AUD_LAST  = 8'd21;
  localparam logic [7:0] SPR_FIRST = 8'd23;
  localparam logic [7:0] SPR_LAST  = 8'd53;

endpackage

// File: rtl/dma_slot_arbiter_if.sv
// Request/grant bundle between the DMA requesters and the slot scheduler.
//   requests : disk_req, aud_req[3:0], spr_req[7:0], bpl_req, cop_req,
//              blt_req, blt_nasty, cpu_req
//   results  : slot_owner, slot_index, slot_start, hpos, line_start, long_line
// master = requester side, slave = scheduler.
interface dma_slot_arbiter_if;

  logic             disk_req;
  logic [3:0]       aud_req;
  logic [7:0]       spr_req;
  logic             bpl_req;
  logic             cop_req;
  logic             blt_req;
  logic             blt_nasty;
  logic             cpu_req;
  dma_pkg::owner_t  slot_owner;
  logic [2:0]       slot_index;
  logic             slot_start;
  logic [7:0]       hpos;
  logic             line_start;
  logic             long_line;

  modport master (
    output disk_req, aud_req, spr_req, bpl_req, cop_req, blt_req, blt_nasty, cpu_req,
    input  slot_owner, slot_index, slot_start, hpos, line_start, long_line
  );

  modport slave (
    input  disk_req, aud_req, spr_req, bpl_req, cop_req, blt_req, blt_nasty, cpu_req,
    output slot_owner, slot_index, slot_start, hpos, line_start, long_line
  );

endinterface

// File: rtl/dma_fixed_slot_decode.sv
// Combinational map from a slot number to its fixed-slot channel.
//   hpos        in  8  slot number being decoded
//   fixed_owner out 4  REFRESH/DISK/AUD/SPR, IDLE when not a fixed slot
//   fixed_index out 3  audio channel or sprite number, else 0
//   fixed_valid out 1  hpos is a fixed slot (request not considered here)
module dma_fixed_slot_decode
  import dma_pkg::*;
(
  input  logic [7:0] hpos,
  output owner_t     fixed_owner,
  output logic [2:0] fixed_index,
  output logic       fixed_valid
);

  always_comb begin
    fixed_owner = IDLE;
    fixed_index = '0;
    fixed_valid = 1'b0;
    if (hpos[0]) begin
      if (hpos >= REF_FIRST && hpos <= REF_LAST) begin
        fixed_owner = REFRESH;
        fixed_valid = 1'b1;
      end else if (hpos >= DSK_FIRST && hpos <= DSK_LAST) begin
        fixed_owner = DISK;
        fixed_valid = 1'b1;
      end else if (hpos >= AUD_FIRST && hpos <= AUD_LAST) begin
        fixed_owner = AUD;
        fixed_index = 3'((hpos - AUD_FIRST) >> 1);
        fixed_valid = 1'b1;
      end else if (hpos >= SPR_FIRST && hpos <= SPR_LAST) begin
        // Two odd slots per sprite, so four hpos steps per sprite number.
        fixed_owner = SPR;
        fixed_index = 3'((hpos - SPR_FIRST) >> 2);
        fixed_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_slot_arbiter.sv
// Chip-bus DMA slot scheduler. Finds CCK slot boundaries (falling CCK edge
// seen on C28M), advances the horizontal slot counter and assigns each slot
// to one owner: fixed channels first, then BPL > COP > BLT > CPU.
//   C28M, RESETn (sync, active-low), CCK : clock, reset, colour clock
//   bus (slave)  : requests in; slot_owner/index/start, hpos, line_start,
//                  long_line out, all registered and held for the slot
module dma_slot_arbiter
  import dma_pkg::*;
#(
  parameter int unsigned LINE_LEN    = 227,
  parameter bit          LOL_EN      = 1'b0,
  parameter int unsigned NASTY_LIMIT = 3
) (
  input  logic               C28M,
  input  logic               RESETn,
  input  logic               CCK,
  dma_slot_arbiter_if.slave  bus
);

  localparam int unsigned    CW         = $clog2(NASTY_LIMIT + 2);
  localparam logic [CW-1:0]  LIMIT      = CW'(NASTY_LIMIT);
  localparam logic [7:0]     LAST_SHORT = 8'(LINE_LEN - 1);

  logic          cck_q;
  logic [CW-1:0] nasty_cnt;
  owner_t        owner_q;
  logic [2:0]    index_q;
  logic [7:0]    hpos_q;
  logic          start_q;
  logic          line_q;
  logic          long_q;

  logic          detect;
  logic          wrap;
  logic [7:0]    last_slot;
  logic [7:0]    hpos_nxt;
  owner_t        fx_owner;
  logic [2:0]    fx_index;
  logic          fx_valid;
  logic          fx_taken;
  logic          force_cpu;
  owner_t        owner_nxt;
  logic [2:0]    index_nxt;
  logic [CW-1:0] nasty_nxt;

  assign detect    = cck_q & ~CCK;
  assign last_slot = LAST_SHORT + {7'd0, long_q};
  assign wrap      = (hpos_q == last_slot);
  assign hpos_nxt  = wrap ? '0 : hpos_q + 8'd1;

  // Owner is resolved for the slot being entered, hence hpos_nxt.
  dma_fixed_slot_decode u_fixed (
    .hpos        (hpos_nxt),
    .fixed_owner (fx_owner),
    .fixed_index (fx_index),
    .fixed_valid (fx_valid)
  );

  always_comb begin
    case (fx_owner)
      REFRESH: fx_taken = 1'b1;
      DISK:    fx_taken = bus.disk_req;
      AUD:     fx_taken = bus.aud_req[fx_index[1:0]];
      SPR:     fx_taken = bus.spr_req[fx_index];
      default: fx_taken = 1'b0;
    endcase
    fx_taken = fx_taken & fx_valid;
  end

  always_comb begin
    owner_nxt = IDLE;
    index_nxt = '0;
    nasty_nxt = nasty_cnt;
    force_cpu = (nasty_cnt == LIMIT) && !bus.blt_nasty;
    if (fx_taken) begin
      owner_nxt = fx_owner;
      index_nxt = fx_index;
    end else if (bus.bpl_req) begin
      owner_nxt = BPL;
    end else if (bus.cop_req && !hpos_nxt[0]) begin
      owner_nxt = COP;
    end else if (bus.blt_req && !(force_cpu && bus.cpu_req)) begin
      owner_nxt = BLT;
      if (bus.cpu_req && !bus.blt_nasty) nasty_nxt = nasty_cnt + CW'(1);
    end else if (bus.cpu_req) begin
      // Also reached when the blitter is held off by the nasty limit.
      owner_nxt = CPU;
    end
    if (!bus.cpu_req || bus.blt_nasty || owner_nxt == CPU) nasty_nxt = '0;
  end

  always_ff @(posedge C28M) begin
    if (!RESETn) begin
      cck_q     <= 1'b1;
      nasty_cnt <= '0;
      owner_q   <= IDLE;
      index_q   <= '0;
      hpos_q    <= '0;
      start_q   <= 1'b0;
      line_q    <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      cck_q   <= CCK;
      start_q <= detect;
      line_q  <= detect & wrap;
      if (detect) begin
        hpos_q    <= hpos_nxt;
        owner_q   <= owner_nxt;
        index_q   <= index_nxt;
        nasty_cnt <= nasty_nxt;
        if (wrap && LOL_EN) long_q <= ~long_q;
      end
    end
  end

  assign bus.slot_owner = owner_q;
  assign bus.slot_index = index_q;
  assign bus.slot_start = start_q;
  assign bus.hpos       = hpos_q;
  assign bus.line_start = line_q;
  assign bus.long_line  = long_q;

endmodule
